// File: rtl/dispatch_queue_if.sv
// Flush request interface shared by the rename/dispatch stages.
interface squash_if;
    logic valid;

    modport master (output valid);
    modport slave  (input  valid);
endinterface

// File: rtl/dispatch_queue.sv
// In-order buffer between rename and issue, with a physical-register busy
// scoreboard used to annotate the head entry with operand readiness.
package dispatch_queue_pkg;
    localparam int unsigned PRFSIZE = 64;

    typedef logic [$clog2(PRFSIZE)-1:0] preg_id_t;

    typedef struct packed {
        logic       rd_valid;
        logic       rs1_valid;
        logic       rs2_valid;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } si_t;

    typedef struct packed {
        si_t        si;
        preg_id_t   prd;
        preg_id_t   prs1;
        preg_id_t   prs2;
        logic       prs1_renammed;
        logic       prs2_renammed;
        logic [15:0] pc;
    } di_t;
endpackage

module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_BITS = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  di_t                 di_i,
    input  logic                di_i_valid,
    output logic                di_i_ready,
    output di_t                 di_o,
    output logic                di_o_valid,
    input  logic                di_o_ready,
    output logic                prs1_ready_o,
    output logic                prs2_ready_o,
    input  logic                wb_valid_i,
    input  preg_id_t            wb_preg_i,
    squash_if.slave             squash_io,
    output logic [CNT_BITS-1:0] count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(DEPTH);

    di_t                 mem [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_BITS-1:0] count;
    logic [PRFSIZE-1:0]  busy;
    logic [PRFSIZE-1:0]  busy_n;
    logic                flush;
    logic                enq;
    logic                deq;
    di_t                 h;

    assign flush      = rst || squash_io.valid;
    assign di_i_ready = (count < FULL);
    assign di_o_valid = (count != '0);
    assign enq        = di_i_valid && di_i_ready;
    assign deq        = di_o_valid && di_o_ready;
    assign h          = mem[head];
    assign di_o       = h;
    assign count_o    = count;

    // Writeback clear is applied first so a same-cycle producer set wins.
    always_comb begin
        busy_n = busy;
        if (wb_valid_i)
            busy_n[wb_preg_i] = 1'b0;
        if (enq && di_i.si.rd_valid)
            busy_n[di_i.prd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
        end else begin
            if (enq)
                tail <= tail + 1'b1;
            if (deq)
                head <= head + 1'b1;
            count <= count + CNT_BITS'(enq) - CNT_BITS'(deq);
            busy  <= busy_n;
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !flush)
            mem[tail] <= di_i;
    end

    always_comb begin
        prs1_ready_o = di_o_valid &&
                       (!h.si.rs1_valid || !h.prs1_renammed || !busy[h.prs1] ||
                        (wb_valid_i && wb_preg_i == h.prs1));
        prs2_ready_o = di_o_valid &&
                       (!h.si.rs2_valid || !h.prs2_renammed || !busy[h.prs2] ||
                        (wb_valid_i && wb_preg_i == h.prs2));
    end

    a_no_enq_when_full: assert property (@(posedge clk) disable iff (rst)
        !(enq && count == FULL));

    a_head_stable: assert property (@(posedge clk) disable iff (rst)
        (di_o_valid && !di_o_ready && !squash_io.valid) |=> $stable(di_o));
endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Buffer stage directly downstream of rename; decouples rename from issue.
- Holds up to DEPTH renamed instructions (di_t) in order.
- Keeps a physical-register busy scoreboard: busy is set when a producer is enqueued and cleared on writeback broadcast.
- Annotates the head instruction with per-source operand readiness for the issue stage.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- CNT_BITS, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous reset, active-high.
- di_i  in  di_t  renamed instruction from rename.
- di_i_valid  in  1  di_i present.
- di_i_ready  out  1  queue can accept this cycle.
- di_o  out  di_t  head instruction.
- di_o_valid  out  1  head valid.
- di_o_ready  in  1  issue stage consumes head.
- prs1_ready_o  out  1  head source 1 operand available.
- prs2_ready_o  out  1  head source 2 operand available.
- wb_valid_i  in  1  writeback broadcast valid.
- wb_preg_i  in  preg_id_t  physical register written back.
- squash_io  squash_if.slave  iface  flush request, uses .valid.
- count_o  out  CNT_BITS  current occupancy.

Behaviour:
- Reset (rst=1 at posedge): head=tail=count=0, busy[PRFSIZE-1:0]=0. Outputs after reset: di_o_valid=0, di_i_ready=1, count_o=0, prs*_ready_o=0.
- Storage: circular array of DEPTH di_t entries; head/tail pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Enqueue: enq = di_i_valid && di_i_ready. Writes mem[tail] and increments tail.
- Dequeue: deq = di_o_valid && di_o_ready. Increments head.
- di_i_ready = (count < DEPTH). It is a registered-state function only; it does not depend on di_o_ready. When full, nothing is accepted even if a dequeue happens in the same cycle.
- di_o_valid = (count != 0). di_o = mem[head], driven combinationally from the array.
- Latency: an instruction enqueued at cycle N appears on di_o at cycle N+1 at the earliest. There is no empty-queue bypass.
- Count update: count += enq - deq. Simultaneous enq and deq leave count unchanged. count never exceeds DEPTH or goes below 0.
- Scoreboard set: on enq with di_i.si.rd_valid, busy[di_i.prd] <= 1.
- Scoreboard clear: on wb_valid_i, busy[wb_preg_i] <= 0.
- Same-preg set and clear in one cycle: set wins.
- Readiness, combinational on the head entry, with h = mem[head]:
  - prs1_ready_o = di_o_valid && (!h.si.rs1_valid || !h.prs1_renammed || !busy[h.prs1] || (wb_valid_i && wb_preg_i==h.prs1)).
  - prs2_ready_o follows the same rule using rs2/prs2.
  - The wb_valid_i term is the same-cycle writeback bypass.
- Readiness is advisory only; dequeue is controlled solely by di_o_ready.
- Squash (squash_io.valid=1 at posedge): head=tail=count=0 and busy cleared to all 0, matching rename's RMT clear.
  - Squash overrides any enq, deq, or writeback in the same cycle; a concurrently offered instruction is dropped.
  - di_i_ready = 1 in the following cycle.
- rst and squash together: reset behaviour (identical effect).
- In-order only: no reordering and no partial flush.
- Assertions:
  - No enqueue when count==DEPTH.
  - di_o stable while di_o_valid && !di_o_ready and there is no squash.

Test Plan:
- Reset, then push 1 instruction (rd_valid, prd=5) at cycle 1 with di_o_ready=0 -> cycle 2: di_o_valid=1, count_o=1, di_o.prd=5; busy[5]=1.
- Fill with DEPTH=4 entries while di_o_ready=0 -> di_i_ready=0 after 4th; 5th offer is not accepted; then drain with di_o_ready=1 -> outputs come in FIFO order with ids 0..3; count_o goes 4,3,2,1,0; pointers wrap on refill.
- Consumer reads prs1=5 (renamed, rs1_valid), busy[5]=1 -> prs1_ready_o=0. Assert wb_valid_i with wb_preg_i=5 -> prs1_ready_o=1 in the same cycle, and it stays 1 afterward.
- Source not renamed (prs1_renammed=0) or rs1_valid=0 -> prs1_ready_o=1 regardless of busy state.
- Same cycle: enqueue a producer of prd=7 and wb_valid_i with wb_preg_i=7 -> busy[7]=1 (set wins).
- With count=3, assert squash_io.valid together with di_i_valid -> next cycle count_o=0, di_o_valid=0, di_i_ready=1, all busy=0, and the offered instruction is never output.
